// File: rtl/bus_rr_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_interconnect
// Purpose  : Round-robin arbiter and master/slave router for N serial masters
//            and N serial slaves. Grants are held for a whole transaction,
//            guarded by a watchdog, and out-of-range selects are aborted.
// Revision : 1.0 - initial release
// ============================================================================
module bus_rr_interconnect #(
    parameter int N_MASTERS = 4,
    parameter int N_SLAVES  = 4,
    parameter int SEL_W     = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_MASTERS-1:0]         m_request,
    input  logic [N_MASTERS*SEL_W-1:0]   m_slave_sel,
    input  logic [N_MASTERS-1:0]         m_ready,
    input  logic [N_MASTERS-1:0]         m_valid,
    input  logic [N_MASTERS-1:0]         m_write_en,
    input  logic [N_MASTERS-1:0]         m_read_en,
    input  logic [N_MASTERS-1:0]         m_data,
    input  logic [N_MASTERS-1:0]         m_done,
    output logic [N_MASTERS-1:0]         m_grant,
    output logic [N_MASTERS-1:0]         m_abort,
    output logic [N_MASTERS-1:0]         m_s_valid,
    output logic [N_MASTERS-1:0]         m_s_ready,
    output logic [N_MASTERS-1:0]         m_s_data,
    output logic [N_SLAVES-1:0]          s_ready,
    output logic [N_SLAVES-1:0]          s_valid,
    output logic [N_SLAVES-1:0]          s_write_en,
    output logic [N_SLAVES-1:0]          s_read_en,
    output logic [N_SLAVES-1:0]          s_data,
    output logic [N_SLAVES-1:0]          s_done,
    input  logic [N_SLAVES-1:0]          s_valid_in,
    input  logic [N_SLAVES-1:0]          s_ready_in,
    input  logic [N_SLAVES-1:0]          s_data_in,
    output logic                         busy
);

    localparam int OW = $clog2(N_MASTERS);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANTED = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]           r_state;
    logic [N_MASTERS-1:0] r_grant;
    logic [N_MASTERS-1:0] r_abort;
    logic [OW-1:0]        r_ptr;
    logic [TW-1:0]        r_timer;
    logic [OW-1:0]        r_owner;
    logic [SEL_W-1:0]     r_sel;

    logic [1:0]           w_state_nx;
    logic [N_MASTERS-1:0] w_grant_nx;
    logic [N_MASTERS-1:0] w_abort_nx;
    logic [OW-1:0]        w_ptr_nx;
    logic [TW-1:0]        w_timer_nx;
    logic [OW-1:0]        w_owner_nx;
    logic [SEL_W-1:0]     w_sel_nx;

    logic [SEL_W-1:0]     w_sel_arr [N_MASTERS];
    logic                 w_found;
    logic [OW-1:0]        w_win;
    logic [OW-1:0]        w_idx;
    logic [SEL_W-1:0]     w_win_sel;
    logic                 w_win_valid;
    logic                 w_owner_end;
    logic                 w_route_en;

    // Split the packed select bus into one field per master
    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_sel
            assign w_sel_arr[gi] = m_slave_sel[gi*SEL_W +: SEL_W];
        end
    endgenerate

    // Round-robin search: first requester after the pointer, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            w_idx = OW'((int'(r_ptr) + k) % N_MASTERS);
            if (!w_found && m_request[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_sel   = w_sel_arr[w_win];
    assign w_win_valid = (int'(w_win_sel) < N_SLAVES);
    assign w_owner_end = m_done[r_owner] || !m_request[r_owner];

    // Next-state and next-register computation
    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_abort_nx = '0;
        w_ptr_nx   = r_ptr;
        w_timer_nx = r_timer;
        w_owner_nx = r_owner;
        w_sel_nx   = r_sel;
        case (r_state)
            S_GRANTED: begin
                w_timer_nx = r_timer + 1'b1;
                // Normal completion takes precedence over the watchdog
                if (w_owner_end) begin
                    w_state_nx = S_RELEASE;
                    w_grant_nx = '0;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_state_nx          = S_RELEASE;
                    w_grant_nx          = '0;
                    w_abort_nx[r_owner] = 1'b1;
                end
            end
            default: begin
                // IDLE and the RELEASE turnaround both arbitrate
                w_state_nx = S_IDLE;
                w_grant_nx = '0;
                if (w_found) begin
                    w_ptr_nx = w_win;
                    if (w_win_valid) begin
                        w_state_nx        = S_GRANTED;
                        w_grant_nx[w_win] = 1'b1;
                        w_timer_nx        = '0;
                        w_owner_nx        = w_win;
                        w_sel_nx          = w_win_sel;
                    end else begin
                        w_abort_nx[w_win] = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_abort <= '0;
            r_ptr   <= OW'(N_MASTERS - 1);
            r_timer <= '0;
            r_owner <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_abort <= w_abort_nx;
            r_ptr   <= w_ptr_nx;
            r_timer <= w_timer_nx;
            r_owner <= w_owner_nx;
            r_sel   <= w_sel_nx;
        end
    end

    assign m_grant    = r_grant;
    assign m_abort    = r_abort;
    assign busy       = (r_state != S_IDLE);
    assign w_route_en = (r_state == S_GRANTED) && !reset;

    // Routing between the owner and its latched slave; everything else is 0
    always_comb begin
        s_ready    = '0;
        s_valid    = '0;
        s_write_en = '0;
        s_read_en  = '0;
        s_data     = '0;
        s_done     = '0;
        m_s_valid  = '0;
        m_s_ready  = '0;
        m_s_data   = '0;
        if (w_route_en) begin
            for (int j = 0; j < N_SLAVES; j++) begin
                if (r_sel == SEL_W'(j)) begin
                    s_ready[j]         = m_ready[r_owner];
                    s_valid[j]         = m_valid[r_owner];
                    s_write_en[j]      = m_write_en[r_owner];
                    s_read_en[j]       = m_read_en[r_owner];
                    s_data[j]          = m_data[r_owner];
                    s_done[j]          = m_done[r_owner];
                    m_s_valid[r_owner] = s_valid_in[j];
                    m_s_ready[r_owner] = s_ready_in[j];
                    m_s_data[r_owner]  = s_data_in[j];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_rr_interconnect
// Purpose  : Self-checking bench for bus_rr_interconnect (4 masters, 3 slaves,
//            8-cycle watchdog) using vector tables, directed sequences and
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_rr_interconnect;

    localparam int NM = 4;
    localparam int NS = 3;
    localparam int SW = 2;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NM-1:0]   m_request, m_ready, m_valid, m_write_en, m_read_en, m_data, m_done;
    logic [NM*SW-1:0] m_slave_sel;
    logic [NM-1:0]   m_grant, m_abort, m_s_valid, m_s_ready, m_s_data;
    logic [NS-1:0]   s_ready, s_valid, s_write_en, s_read_en, s_data, s_done;
    logic [NS-1:0]   s_valid_in, s_ready_in, s_data_in;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, how long, and where the pointer sits
    int            md_owner;
    int            md_sel;
    int            md_held;
    int            md_ptr;
    bit            md_rel;
    logic [NM-1:0] md_abort;

    bus_rr_interconnect #(
        .N_MASTERS (NM),
        .N_SLAVES  (NS),
        .SEL_W     (SW),
        .TIMEOUT   (TO)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .m_request   (m_request),
        .m_slave_sel (m_slave_sel),
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .m_write_en  (m_write_en),
        .m_read_en   (m_read_en),
        .m_data      (m_data),
        .m_done      (m_done),
        .m_grant     (m_grant),
        .m_abort     (m_abort),
        .m_s_valid   (m_s_valid),
        .m_s_ready   (m_s_ready),
        .m_s_data    (m_s_data),
        .s_ready     (s_ready),
        .s_valid     (s_valid),
        .s_write_en  (s_write_en),
        .s_read_en   (s_read_en),
        .s_data      (s_data),
        .s_done      (s_done),
        .s_valid_in  (s_valid_in),
        .s_ready_in  (s_ready_in),
        .s_data_in   (s_data_in),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [NM-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NM; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        md_owner = -1;
        md_sel   = 0;
        md_held  = 0;
        md_ptr   = NM - 1;
        md_rel   = 0;
        md_abort = '0;
    endtask

    // Advance the model by one clock edge from the inputs seen at that edge
    task automatic model_update();
        logic [NM-1:0] ab;
        int w;
        int s;
        ab = '0;
        if (reset) begin
            model_reset();
            return;
        end
        if (md_owner >= 0) begin
            md_held++;
            if (m_done[md_owner] || !m_request[md_owner]) begin
                md_owner = -1;
                md_rel   = 1;
            end else if (md_held == TO) begin
                ab[md_owner] = 1'b1;
                md_owner     = -1;
                md_rel       = 1;
            end
        end else begin
            md_rel = 0;
            w = -1;
            for (int k = 1; k <= NM; k++)
                if (w < 0 && m_request[(md_ptr + k) % NM]) w = (md_ptr + k) % NM;
            if (w >= 0) begin
                md_ptr = w;
                s = int'(m_slave_sel[w*SW +: SW]);
                if (s < NS) begin
                    md_owner = w;
                    md_sel   = s;
                    md_held  = 0;
                end else begin
                    ab[w] = 1'b1;
                end
            end
        end
        md_abort = ab;
    endtask

    // One cycle: randomize data lines, check all outputs, clock the model
    task automatic step();
        logic [NS-1:0] e_sr, e_sv, e_sw, e_srd, e_sd, e_sdn;
        logic [NM-1:0] e_mv, e_mr, e_md, e_g;
        m_ready    = 4'($urandom);
        m_valid    = 4'($urandom);
        m_write_en = 4'($urandom);
        m_read_en  = 4'($urandom);
        m_data     = 4'($urandom);
        s_valid_in = 3'($urandom);
        s_ready_in = 3'($urandom);
        s_data_in  = 3'($urandom);
        #1;
        e_sr = '0; e_sv = '0; e_sw = '0; e_srd = '0; e_sd = '0; e_sdn = '0;
        e_mv = '0; e_mr = '0; e_md = '0; e_g = '0;
        if (md_owner >= 0) e_g[md_owner] = 1'b1;
        if (!reset && md_owner >= 0) begin
            e_sr[md_sel]   = m_ready[md_owner];
            e_sv[md_sel]   = m_valid[md_owner];
            e_sw[md_sel]   = m_write_en[md_owner];
            e_srd[md_sel]  = m_read_en[md_owner];
            e_sd[md_sel]   = m_data[md_owner];
            e_sdn[md_sel]  = m_done[md_owner];
            e_mv[md_owner] = s_valid_in[md_sel];
            e_mr[md_owner] = s_ready_in[md_sel];
            e_md[md_owner] = s_data_in[md_sel];
        end
        chk("grant", 32'(m_grant), 32'(e_g));
        chk("abort", 32'(m_abort), 32'(md_abort));
        chk("busy", 32'(busy), 32'(md_owner >= 0 || md_rel));
        chk("s_route", 32'({s_ready, s_valid, s_write_en, s_read_en, s_data, s_done}),
            32'({e_sr, e_sv, e_sw, e_srd, e_sd, e_sdn}));
        chk("m_route", 32'({m_s_valid, m_s_ready, m_s_data}), 32'({e_mv, e_mr, e_md}));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        m_request = '0;
        m_done    = '0;
        step();
        reset     = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic [NM-1:0] req;
        logic [7:0]    sel;
        logic [NM-1:0] done;
        logic [NM-1:0] e_grant;
        logic [NM-1:0] e_abort;
        logic          e_busy;
    } vec_t;

    vec_t tbl [11];
    int   rr_exp [5] = '{0, 1, 2, 3, 0};
    int   wrap_exp [3] = '{2, 3, 0};
    logic [NM-1:0] wrap_extra [3] = '{4'b0100, 4'b1000, 4'b0000};

    initial begin
        int order [$];
        int cnt;
        int gap;
        int g;
        logic [NM-1:0] prev;

        // Expected register values after each edge
        tbl[0]  = '{1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 8'h02, 4'b0000, 4'b0001, 4'b0000, 1'b1};
        tbl[2]  = '{1'b0, 4'b0001, 8'h02, 4'b0000, 4'b0001, 4'b0000, 1'b1};
        tbl[3]  = '{1'b0, 4'b0001, 8'h02, 4'b0001, 4'b0000, 4'b0000, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 8'h02, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 8'h30, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 4'b0110, 8'h34, 4'b0000, 4'b0010, 4'b0000, 1'b1};
        tbl[8]  = '{1'b0, 4'b0110, 8'h34, 4'b0010, 4'b0000, 4'b0000, 1'b1};
        tbl[9]  = '{1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        reset = 1'b1; m_request = '0; m_slave_sel = '0; m_done = '0;
        m_ready = '0; m_valid = '0; m_write_en = '0; m_read_en = '0; m_data = '0;
        s_valid_in = '0; s_ready_in = '0; s_data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Vector table
        for (int i = 0; i < 11; i++) begin
            reset       = tbl[i].rst;
            m_request   = tbl[i].req;
            m_slave_sel = tbl[i].sel;
            m_done      = tbl[i].done;
            step();
            chk($sformatf("vec%0d_grant", i), 32'(m_grant), 32'(tbl[i].e_grant));
            chk($sformatf("vec%0d_abort", i), 32'(m_abort), 32'(tbl[i].e_abort));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end

        // Round robin with all masters requesting, done after 5 granted cycles
        do_reset();
        m_request = 4'hF; m_slave_sel = 8'h24; m_done = '0;
        cnt = 0; gap = 0; prev = '0;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            if (m_grant != '0) begin
                if (prev == '0) begin
                    order.push_back(oh2i(m_grant));
                    if (order.size() > 1) chk("rr_gap", 32'(gap), 32'd1);
                    gap = 0;
                end
                cnt++;
                m_done = (cnt == 5) ? m_grant : '0;
            end else begin
                cnt = 0;
                gap++;
                m_done = '0;
            end
            prev = m_grant;
            step();
        end
        chk("rr_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < order.size()) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(rr_exp[i]));

        // Pointer wrap after master 1 finishes while master 0 keeps requesting
        for (int v = 0; v < 3; v++) begin
            do_reset();
            m_slave_sel = 8'h00; m_request = 4'b0010; m_done = '0;
            step();
            m_request = 4'b0011 | wrap_extra[v];
            repeat (3) step();
            m_done = 4'b0010;
            step();
            chk($sformatf("wrap%0d_release", v), 32'(m_grant), 32'd0);
            m_done = '0;
            m_request = 4'b0001 | wrap_extra[v];
            step();
            chk($sformatf("wrap%0d_grant", v), 32'(m_grant), 32'(1 << wrap_exp[v]));
        end

        // Watchdog: owner never finishes
        do_reset();
        m_slave_sel = 8'h00; m_request = 4'b0001; m_done = '0;
        step();
        g = 0;
        while (m_grant[0] && g < 20) begin
            g++;
            step();
        end
        chk("to_cycles", 32'(g), 32'd8);
        chk("to_abort", 32'(m_abort), 32'b0001);
        m_request = '0;
        step();
        chk("to_abort_len", 32'(m_abort), 32'd0);

        // Done on the last permitted cycle beats the watchdog
        do_reset();
        m_request = 4'b0001; m_done = '0;
        step();
        g = 0;
        while (m_grant[0] && g < 20) begin
            g++;
            m_done = (g == 8) ? 4'b0001 : 4'b0000;
            step();
        end
        m_done = '0;
        chk("done8_cycles", 32'(g), 32'd8);
        chk("done8_abort", 32'(m_abort), 32'd0);

        // Reset in the middle of a granted transaction
        do_reset();
        m_request = 4'b0100; m_slave_sel = 8'h10;
        step();
        step();
        chk("rst_pre_grant", 32'(m_grant), 32'b0100);
        reset = 1'b1;
        step();
        chk("rst_grant", 32'(m_grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_abort", 32'(m_abort), 32'd0);
        reset = 1'b0;
        m_request = 4'hF; m_slave_sel = 8'h00;
        step();
        chk("rst_first", 32'(m_grant), 32'b0001);

        // Randomized traffic checked every cycle by the model
        m_request = '0;
        m_done    = '0;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NM; i++)
                if ($urandom_range(0, 7) == 0) m_request[i] = ~m_request[i];
            if ($urandom_range(0, 3) == 0) m_slave_sel = 8'($urandom);
            for (int i = 0; i < NM; i++) m_done[i] = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
